booth_r8_edge_feeder: RTL
=========================

// Module: booth_r8_edge_feeder
// PURPOSE
//  Edge feeder for the radix-8 output-stationary systolic array. Accepts raw signed operand
//  pairs (multiplier X, multiplicand Y) over a valid/ready stream and encodes X into per-group
//  radix-8 Booth digit controls (s,d,t,q,n). It also precomputes TMY = 3*Y. Drives one PE row
//  edge; tracks K-length accumulation tiles and flags the last beat of each tile.
// PARAMETERS
//  WIDTH  8   operand width; legal values 4, 8, 12 (GC must equal ceil(WIDTH/3)); other values -> $error
//  GC     (WIDTH>>2)+1  Booth group count, derived; not overridable
//  KW     16  width of tile-length field K_LEN
// PORTS
//  CLK        in   1        clock, all logic rising-edge
//  RST        in   1        synchronous, active-high reset
//  IN_VALID   in   1        operand pair valid
//  IN_READY   out  1        feeder can accept operand pair
//  X_IN       in   WIDTH    signed multiplier, Booth-encoded
//  Y_IN       in   WIDTH    signed multiplicand
//  K_LEN      in   KW       beats per tile; sampled on first accepted beat of a tile
//  OUT_VALID  out  1        encoded beat valid
//  OUT_READY  in   1        array edge accepts beat
//  S_OUT,D_OUT,T_OUT,Q_OUT,N_OUT  out  GC  per-group digit |v|=1,2,3,4 one-hot; N = digit negative
//  Y_OUT      out  WIDTH    registered Y
//  TMY_OUT    out  WIDTH+2  3*Y, signed, sign-extended
//  OUT_LAST   out  1        qualifies OUT_VALID: final beat of current tile
//  TILE_DONE  out  1        one-cycle pulse, cycle after last beat's output handshake
//  BUSY       out  1        tile in progress (state RUN)
// BEHAVIOUR
//  Reset: all outputs 0 except IN_READY=1; pipeline empty; state IDLE; beat counter 0.
//  Encoding: x[-1]=0, X sign-extended to 3*GC+1 bits. Group i uses bits {3i+2,3i+1,3i,3i-1}.
//   v = -4*b3 + 2*b2 + b1 + b0, in [-4,4]. Exactly one of s/d/t/q set per |v|; all 0 for v=0.
//   n=1 iff v<0; n=0 for v=0 (both 0000 and 1111 patterns).
//  TMY = (Y<<1)+Y computed at WIDTH+2 bits; no overflow possible.
//  Pipeline: 2 register stages (S1 capture, S2 encode+3Y). Latency: accept at edge N
//   -> OUT_VALID at edge N+2 when no stall. Throughput 1 beat/cycle.
//  Handshake: transfer on VALID&READY at rising edge. S2 advances when !S2_valid|OUT_READY.
//   S1 advances when S2 advances or S1 empty; IN_READY = !S1_valid | S1 advances.
//   Output data stable while OUT_VALID & !OUT_READY; no bubble inserted when stalls release.
//  FSM IDLE->RUN on first accepted input; K latched as max(K_LEN,1), so K_LEN=0 behaves as 1.
//   Input beat counter tags S1 entry with last=(in_cnt==K-1); in_cnt wraps to 0 on tag.
//   After the tagged beat is accepted, IN_READY=0 until the tile drains. Tiles never interleave in pipe.
//   RUN->IDLE on output handshake of the last-tagged beat; TILE_DONE=1 the following cycle.
//   Back-to-back tile: new input accepted the cycle TILE_DONE is high (IN_READY=1 in IDLE).
//  K_LEN changes mid-tile are ignored. RST mid-tile flushes both stages and drops in-flight beats.
//   Outputs return to reset values the cycle after RST is sampled high.
// CONFIGURATION
//  BOOTH_FEED_ZERO_GATE_EN defined: a beat whose X encodes all-zero digits
//   (all s/d/t/q = 0) drives Y_OUT=0 and TMY_OUT=0 to cut downstream toggling.
//   Digits, OUT_LAST, timing and handshake are unchanged.
//  Not defined: Y_OUT/TMY_OUT always carry the true Y and 3*Y. No gating logic is instantiated.
// TESTING
//  1 Reset: RST high 2 cycles -> OUT_VALID=0, IN_READY=1, BUSY=0, all digit buses 0.
//  2 Encode, WIDTH=8:
//    X=127 -> S=001 D=100 T=000 Q=000 N=001
//    X=-128 -> D=100 N=100, others 0
//    X=36 -> S=100 T=010 Q=001 N=011
//    Y=-3 -> TMY=10'h3F7; Y=127 -> TMY=10'h17D
//  3 Streaming: K_LEN=4, 4 beats back-to-back, OUT_READY=1 -> outputs 2 cycles after each accept.
//    OUT_LAST on beat 4 only; TILE_DONE one cycle later; BUSY 1->0.
//  4 Stall: OUT_READY=0 for 5 cycles mid-tile -> IN_READY falls after 2 beats buffered.
//    Outputs held stable; no beat lost or duplicated after release.
//  5 Boundary: K_LEN=0 -> every beat flagged OUT_LAST and TILE_DONE pulses per beat.
//    RST asserted with 2 beats in flight -> no OUT_VALID afterwards; next tile counts from 0.
//  6 With BOOTH_FEED_ZERO_GATE_EN: X=0, Y=55 -> digits 0, Y_OUT=0, TMY_OUT=0.
//    Without the macro -> Y_OUT=55, TMY_OUT=165.

Source files
------------

// File: rtl/booth_r8_edge_feeder.sv
// booth_r8_edge_feeder
// Edge feeder for a radix-8 output-stationary systolic array row.
// - Accepts signed (X, Y) operand pairs on a valid/ready stream.
// - Encodes X into per-group radix-8 Booth digit controls.
// - Precomputes 3*Y.
// - Tags the final beat of each K-beat tile.
//
// Handshake: a beat transfers on a rising edge where VALID and READY are both high.
// READY never depends on VALID of the same interface. Data held under VALID & !READY
// stays stable until the transfer.
//
// Optional feature: define BOOTH_FEED_ZERO_GATE_EN to force Y_OUT/TMY_OUT to zero on
// beats whose X encodes to all-zero digits.
module booth_r8_edge_feeder #(
    parameter int  WIDTH = 8,
    parameter int  KW    = 16,
    localparam int GC    = (WIDTH >> 2) + 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   X_IN,
    input  logic [WIDTH-1:0]   Y_IN,
    input  logic [KW-1:0]      K_LEN,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [GC-1:0]      S_OUT,
    output logic [GC-1:0]      D_OUT,
    output logic [GC-1:0]      T_OUT,
    output logic [GC-1:0]      Q_OUT,
    output logic [GC-1:0]      N_OUT,
    output logic [WIDTH-1:0]   Y_OUT,
    output logic [WIDTH+1:0]   TMY_OUT,
    output logic               OUT_LAST,
    output logic               TILE_DONE,
    output logic               BUSY
);

    // X sign-extended to 3*GC+1 bits, plus the implicit x[-1]=0 at bit 0
    localparam int XE = 3 * GC + 2;

    if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 12)) begin : g_bad_width
        $error("booth_r8_edge_feeder: WIDTH must be 4, 8 or 12");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [KW-1:0]      k_q;
    logic [KW-1:0]      in_cnt_q;
    logic               tag_sent_q;
    logic               tile_done_q;

    logic               s1_valid_q;
    logic               s1_last_q;
    logic [WIDTH-1:0]   s1_x_q;
    logic [WIDTH-1:0]   s1_y_q;

    logic               s2_valid_q;
    logic               s2_last_q;
    logic [GC-1:0]      s2_s_q, s2_d_q, s2_t_q, s2_q_q, s2_n_q;
    logic [WIDTH-1:0]   s2_y_q;
    logic [WIDTH+1:0]   s2_tmy_q;

    logic               s2_adv;
    logic               in_ready;
    logic               in_fire;
    logic               last_out_fire;
    logic [KW-1:0]      k_eff;
    logic               in_last;

    logic [XE-1:0]      xe;
    logic [3:0]         grp;
    logic [GC-1:0]      enc_s, enc_d, enc_t, enc_q, enc_n;
    logic [WIDTH+1:0]   tmy;
    logic [WIDTH-1:0]   y_sel;
    logic [WIDTH+1:0]   tmy_sel;

    // Handshake control.
    // S1 drains into S2 whenever S2 advances.
    // Input is blocked once the tile's tagged beat has been accepted.
    always_comb begin
        s2_adv        = !s2_valid_q || OUT_READY;
        in_ready      = !tag_sent_q && (!s1_valid_q || s2_adv);
        in_fire       = IN_VALID && in_ready;
        last_out_fire = s2_valid_q && OUT_READY && s2_last_q;
        k_eff         = (state_q == ST_IDLE)
                        ? ((K_LEN == '0) ? KW'(1) : K_LEN)
                        : k_q;
        in_last       = (in_cnt_q == (k_eff - KW'(1)));
    end

    // Radix-8 Booth digit decode of the S1 multiplier, plus 3*Y
    always_comb begin
        xe    = {{(XE - 1 - WIDTH){s1_x_q[WIDTH-1]}}, s1_x_q, 1'b0};
        grp   = '0;
        enc_s = '0;
        enc_d = '0;
        enc_t = '0;
        enc_q = '0;
        enc_n = '0;
        for (int i = 0; i < GC; i++) begin
            grp = xe[3*i +: 4];
            case (grp)
                4'b0001, 4'b0010: enc_s[i] = 1'b1;
                4'b1101, 4'b1110: begin enc_s[i] = 1'b1; enc_n[i] = 1'b1; end
                4'b0011, 4'b0100: enc_d[i] = 1'b1;
                4'b1011, 4'b1100: begin enc_d[i] = 1'b1; enc_n[i] = 1'b1; end
                4'b0101, 4'b0110: enc_t[i] = 1'b1;
                4'b1001, 4'b1010: begin enc_t[i] = 1'b1; enc_n[i] = 1'b1; end
                4'b0111:          enc_q[i] = 1'b1;
                4'b1000:          begin enc_q[i] = 1'b1; enc_n[i] = 1'b1; end
                default:          ;
            endcase
        end
        tmy = {{2{s1_y_q[WIDTH-1]}}, s1_y_q} + {s1_y_q[WIDTH-1], s1_y_q, 1'b0};
`ifdef BOOTH_FEED_ZERO_GATE_EN
        if ((enc_s | enc_d | enc_t | enc_q) == '0) begin
            y_sel   = '0;
            tmy_sel = '0;
        end else begin
            y_sel   = s1_y_q;
            tmy_sel = tmy;
        end
`else
        y_sel   = s1_y_q;
        tmy_sel = tmy;
`endif
    end

    // Two-stage data pipeline: S1 captures operands, S2 holds the encoded beat
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_s_q     <= '0;
            s2_d_q     <= '0;
            s2_t_q     <= '0;
            s2_q_q     <= '0;
            s2_n_q     <= '0;
            s2_y_q     <= '0;
            s2_tmy_q   <= '0;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                s1_last_q  <= in_last;
                s1_x_q     <= X_IN;
                s1_y_q     <= Y_IN;
            end else if (s2_adv) begin
                s1_valid_q <= 1'b0;
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                s2_last_q  <= s1_valid_q && s1_last_q;
                if (s1_valid_q) begin
                    s2_s_q   <= enc_s;
                    s2_d_q   <= enc_d;
                    s2_t_q   <= enc_t;
                    s2_q_q   <= enc_q;
                    s2_n_q   <= enc_n;
                    s2_y_q   <= y_sel;
                    s2_tmy_q <= tmy_sel;
                end
            end
        end
    end

    // Tile FSM: beat counting, last-beat tagging, input blocking and done pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            in_cnt_q    <= '0;
            tag_sent_q  <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            tile_done_q <= last_out_fire;
            case (state_q)
                ST_IDLE: begin
                    if (in_fire) begin
                        state_q <= ST_RUN;
                        k_q     <= k_eff;
                    end
                end
                ST_RUN: begin
                    if (last_out_fire) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (in_fire) begin
                in_cnt_q <= in_last ? '0 : (in_cnt_q + KW'(1));
            end
            if (in_fire && in_last) begin
                tag_sent_q <= 1'b1;
            end else if (last_out_fire) begin
                tag_sent_q <= 1'b0;
            end
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_VALID = s2_valid_q;
    assign OUT_LAST  = s2_last_q;
    assign S_OUT     = s2_s_q;
    assign D_OUT     = s2_d_q;
    assign T_OUT     = s2_t_q;
    assign Q_OUT     = s2_q_q;
    assign N_OUT     = s2_n_q;
    assign Y_OUT     = s2_y_q;
    assign TMY_OUT   = s2_tmy_q;
    assign TILE_DONE = tile_done_q;
    assign BUSY      = (state_q == ST_RUN);

endmodule
